rf_loader: RTL and testbench

- Write-side sequencer for the RF block. It accepts a stream of 16-bit words over a valid/ready handshake and packs them into 16-lane rows.
- Each completed row is written into RF via the WRITE, IDX and DATA_IN_0..F interface, with IDX counting up from 0.
- After the final row it holds one extra flush cycle, because RF stages write data in a buffer for one cycle before committing it. Only then does it signal DONE, so the array controller can start the read-out phase.

---
 rtl/rf_pkg.sv | 28 ++
 rtl/rf_row_packer.sv | 54 +++++
 rtl/rf_loader.sv | 141 ++++++++++++++
 tb/tb_rf_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants, FSM states and lane helpers for the RF write loader.
// Imported by rf_loader and rf_row_packer.
package rf_pkg;

    localparam int DW     = 16;
    localparam int LANES  = 16;
    localparam int ROWS   = 16;
    localparam int IDX_W  = 5;
    localparam int LANE_W = $clog2(LANES);
    localparam int ROW_W  = LANES * DW;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_WR,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // Extract lane k from a packed row.
    function automatic logic [DW-1:0] lane_slice(
        input logic [ROW_W-1:0] row,
        input int               k
    );
        return row[k*DW +: DW];
    endfunction

endpackage

// File: rtl/rf_row_packer.sv
// Lane counter and row buffer: packs stream words into one RF row,
// zero-fills the tail on the last word and clears between rows.
module rf_row_packer
    import rf_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             last_i,
    input  logic [DW-1:0]    data_i,
    output logic             full_o,
    output logic [ROW_W-1:0] row_o
);

    logic [LANE_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0]  row_q, row_d;

    // Next row: place the word in the current lane, zero later lanes on last.
    always_comb begin
        cnt_d = cnt_q;
        row_d = row_q;
        if (clear_i) begin
            cnt_d = '0;
            row_d = '0;
        end else if (push_i) begin
            cnt_d = cnt_q + LANE_W'(1);
            for (int k = 0; k < LANES; k++) begin
                if (LANE_W'(k) == cnt_q) begin
                    row_d[k*DW +: DW] = data_i;
                end else if (last_i && (LANE_W'(k) > cnt_q)) begin
                    row_d[k*DW +: DW] = '0;
                end else begin
                    row_d[k*DW +: DW] = lane_slice(row_q, k);
                end
            end
        end
    end

    // Lane counter and row buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

    assign full_o = (cnt_q == LANE_W'(LANES - 1));
    assign row_o  = row_q;

endmodule

// File: rtl/rf_loader.sv
// Write-side sequencer for RF: packs a word stream into rows, writes them
// with an incrementing index, holds one flush cycle, then pulses DONE.
module rf_loader
    import rf_pkg::*;
(
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             START,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [DW-1:0]    S_DATA,
    input  logic             S_LAST,
    output logic             RF_EN,
    output logic             WRITE,
    output logic [IDX_W-1:0] IDX,
    output logic [ROW_W-1:0] RF_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic [IDX_W-1:0] ROWS_WR,
    output logic             OVF
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rows_wr_q, rows_wr_d;
    logic             last_q, last_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q, wr_q, en_q, busy_q, done_q;
    logic             hs;
    logic             row_full;
    logic             pk_clear;
    logic             at_top;

    assign hs     = (state_q == ST_FILL) & S_VALID;
    assign at_top = (row_cnt_q == IDX_W'(ROWS - 1));

    rf_row_packer u_packer (
        .clk_i   (CLK),
        .rst_ni  (RSTN),
        .clear_i (pk_clear),
        .push_i  (hs),
        .last_i  (S_LAST),
        .data_i  (S_DATA),
        .full_o  (row_full),
        .row_o   (RF_DATA)
    );

    // Next-state, counter and flag logic.
    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        idx_d     = idx_q;
        rows_wr_d = rows_wr_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        pk_clear  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d   = ST_FILL;
                    row_cnt_d = '0;
                    idx_d     = '0;
                    rows_wr_d = '0;
                    last_d    = 1'b0;
                    ovf_d     = 1'b0;
                    pk_clear  = 1'b1;
                end
            end
            ST_FILL: begin
                if (hs && (row_full || S_LAST)) begin
                    state_d = ST_WR;
                    idx_d   = row_cnt_q;
                    last_d  = last_q | S_LAST;
                end
            end
            ST_WR: begin
                row_cnt_d = row_cnt_q + IDX_W'(1);
                if (last_q || at_top) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d  = ST_FILL;
                    pk_clear = 1'b1;
                end
                if (at_top && !last_q) begin
                    ovf_d = 1'b1;
                end
            end
            ST_FLUSH: begin
                state_d   = ST_DONE;
                rows_wr_d = row_cnt_q;
                pk_clear  = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, counters and registered outputs decoded from next state.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_IDLE;
            row_cnt_q <= '0;
            idx_q     <= '0;
            rows_wr_q <= '0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rdy_q     <= 1'b0;
            wr_q      <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            idx_q     <= idx_d;
            rows_wr_q <= rows_wr_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            rdy_q     <= (state_d == ST_FILL);
            wr_q      <= (state_d == ST_WR) || (state_d == ST_FLUSH);
            en_q      <= state_d inside {ST_FILL, ST_WR, ST_FLUSH};
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign S_READY = rdy_q;
    assign WRITE   = wr_q;
    assign RF_EN   = en_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign IDX     = idx_q;
    assign ROWS_WR = rows_wr_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_rf_loader.sv
// Scoreboard bench for rf_loader: a row-level model predicts every RF write
// and each DONE; a negedge monitor pops and compares what the DUT presents.
module tb_rf_loader;
    import rf_pkg::*;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             START;
    logic             S_VALID;
    logic             S_READY;
    logic [DW-1:0]    S_DATA;
    logic             S_LAST;
    logic             RF_EN;
    logic             WRITE;
    logic [IDX_W-1:0] IDX;
    logic [ROW_W-1:0] RF_DATA;
    logic             BUSY;
    logic             DONE;
    logic [IDX_W-1:0] ROWS_WR;
    logic             OVF;

    typedef struct {
        int               idx;
        logic [ROW_W-1:0] data;
    } row_t;

    typedef struct {
        int rows;
        bit ovf;
        int words;
    } done_t;

    row_t  exp_rows[$];
    done_t exp_done[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;

    rf_loader dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .START   (START),
        .S_VALID (S_VALID),
        .S_READY (S_READY),
        .S_DATA  (S_DATA),
        .S_LAST  (S_LAST),
        .RF_EN   (RF_EN),
        .WRITE   (WRITE),
        .IDX     (IDX),
        .RF_DATA (RF_DATA),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ROWS_WR (ROWS_WR),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(input string name,
                                input logic [ROW_W-1:0] act,
                                input logic [ROW_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endfunction

    // Model: word j of the load lands in row j/LANES, lane j%LANES;
    // lanes beyond the accepted word count read as zero.
    function automatic void push_rows(input logic [DW-1:0] w[$], input int acc);
        row_t e;
        int   nrows;
        nrows = (acc + LANES - 1) / LANES;
        for (int r = 0; r < nrows; r++) begin
            e.idx  = r;
            e.data = '0;
            for (int l = 0; l < LANES; l++) begin
                if (r * LANES + l < acc) e.data[l*DW +: DW] = w[r * LANES + l];
            end
            exp_rows.push_back(e);
        end
    endfunction

    function automatic void push_done(input int acc, input bit ovf);
        done_t d;
        d.rows  = (acc + LANES - 1) / LANES;
        d.ovf   = ovf;
        d.words = acc;
        exp_done.push_back(d);
    endfunction

    // Monitor: every WRITE rising edge is a row, a second WRITE cycle is the
    // flush, DONE must follow the flush directly.
    initial begin : monitor
        bit    wr_prev;
        bit    fl_prev;
        bit    fl_now;
        int    hs_cnt;
        row_t  cur;
        done_t d;
        wr_prev  = 1'b0;
        fl_prev  = 1'b0;
        hs_cnt   = 0;
        cur.idx  = 0;
        cur.data = '0;
        forever begin
            @(negedge CLK);
            fl_now = 1'b0;
            if (!RSTN) begin
                wr_prev = 1'b0;
                fl_prev = 1'b0;
                hs_cnt  = 0;
            end else begin
                if (S_VALID && S_READY) hs_cnt++;
                if (WRITE || DONE) chk("ready_low_wr_flush_done", S_READY, 0);
                if (WRITE && !wr_prev) begin
                    chk("rf_en_on_write", RF_EN, 1);
                    chk("busy_on_write", BUSY, 1);
                    if (exp_rows.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write idx=%0d", IDX);
                    end else begin
                        cur = exp_rows.pop_front();
                        chk("row_idx", IDX, cur.idx);
                        chk("row_data", RF_DATA, cur.data);
                    end
                end else if (WRITE) begin
                    fl_now = 1'b1;
                    chk("flush_idx", IDX, cur.idx);
                    chk("flush_data", RF_DATA, cur.data);
                end
                if (DONE) begin
                    done_cnt++;
                    chk("done_after_flush", fl_prev, 1);
                    chk("rf_en_low_at_done", RF_EN, 0);
                    if (exp_done.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done rows_wr=%0d", ROWS_WR);
                    end else begin
                        d = exp_done.pop_front();
                        chk("rows_wr", ROWS_WR, d.rows);
                        chk("ovf", OVF, d.ovf);
                        chk("words_accepted", hs_cnt, d.words);
                    end
                    hs_cnt = 0;
                end
                wr_prev = WRITE;
                fl_prev = fl_now;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input bit bub);
        int t;
        if (bub && ($urandom_range(0, 2) == 0)) begin
            S_VALID = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge CLK);
            #1;
        end
        S_VALID = 1'b1;
        S_DATA  = d;
        S_LAST  = last;
        t = 0;
        forever begin
            @(negedge CLK);
            if (S_READY) break;
            t++;
            if (t > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout act=not_ready exp=ready");
                break;
            end
        end
        @(posedge CLK);
        #1;
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        START   = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 200) begin
            @(posedge CLK);
            t++;
        end
        #1;
        checks++;
        if (done_cnt == d0) begin
            errors++;
            $display("FAIL done_timeout act=no_done exp=done");
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("rows_drained", exp_rows.size(), 0);
        chk("idle_not_busy", BUSY, 0);
    endtask

    task automatic run_load(input int n, input bit with_last, input bit rnd,
                            input bit bub, input int dup_at);
        logic [DW-1:0] w[$];
        int            acc;
        int            d0;
        for (int i = 0; i < n; i++) w.push_back(rnd ? DW'($urandom) : DW'(i));
        acc = with_last ? n : ROWS * LANES;
        push_rows(w, acc);
        push_done(acc, !with_last);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < n; i++) begin
            if (!with_last && i >= ROWS * LANES) begin
                S_VALID = 1'b1;
                S_DATA  = w[i];
                @(negedge CLK);
                chk("no_accept_after_ovf", S_READY, 0);
                @(posedge CLK);
                #1;
            end else begin
                if (i == dup_at) START = 1'b1;
                send(w[i], with_last && (i == n - 1), bub);
            end
        end
        S_VALID = 1'b0;
        wait_done(d0);
    endtask

    task automatic reset_midload();
        logic [DW-1:0] w[$];
        int            d0;
        for (int i = 0; i < 40; i++) w.push_back(DW'(i + 1));
        push_rows(w, 32);
        d0 = done_cnt;
        pulse_start();
        for (int i = 0; i < 40; i++) send(w[i], 1'b0, 1'b0);
        #2;
        RSTN = 1'b0;
        #1;
        chk("rst_write", WRITE, 0);
        chk("rst_ready", S_READY, 0);
        chk("rst_rf_en", RF_EN, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_idx", IDX, 0);
        chk("rst_rf_data", RF_DATA, 0);
        chk("rst_rows_wr", ROWS_WR, 0);
        chk("rst_ovf", OVF, 0);
        repeat (3) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_no_done", done_cnt, d0);
        chk("rst_rows_drained", exp_rows.size(), 0);
    endtask

    initial begin
        RSTN    = 1'b1;
        START   = 1'b0;
        S_VALID = 1'b0;
        S_DATA  = '0;
        S_LAST  = 1'b0;
        #2;
        RSTN = 1'b0;
        #5;
        chk("init_write", WRITE, 0);
        chk("init_ready", S_READY, 0);
        chk("init_rf_en", RF_EN, 0);
        chk("init_busy", BUSY, 0);
        chk("init_done", DONE, 0);
        chk("init_idx", IDX, 0);
        chk("init_rf_data", RF_DATA, 0);
        chk("init_rows_wr", ROWS_WR, 0);
        chk("init_ovf", OVF, 0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        run_load(256, 1'b1, 1'b0, 1'b0, -1);
        run_load(20,  1'b1, 1'b0, 1'b0, -1);
        run_load(256, 1'b1, 1'b0, 1'b1, -1);
        run_load(17,  1'b1, 1'b1, 1'b1, -1);
        run_load(16,  1'b1, 1'b1, 1'b0, -1);
        run_load(300, 1'b0, 1'b1, 1'b1, -1);
        reset_midload();
        run_load(37,  1'b1, 1'b1, 1'b1, -1);
        run_load(40,  1'b1, 1'b1, 1'b0, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
